// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, types and sizing helper for the BCD converter
package bcd_pkg;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ceil(n * log10(2)) with log10(2) taken as 0.30103; n*log10(2) is never integral for n > 0
    function automatic int bcd_digits_for(input int n);
        return (n * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/done handshake and result bus of the BCD converter
interface bin2bcd_seq_if #(
    parameter int N = 8,
    parameter int D = 3
);
    logic             start;
    logic [N-1:0]     binary_in;
    logic             busy;
    logic             done;
    logic [4*D-1:0]   bcd_out;
    logic             overflow;

    modport master (
        output start,
        output binary_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  binary_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one double-dabble digit correction (add 3 when >= 5)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= BCD_ADJ_THRESHOLD) ? (i_digit + BCD_ADJ_VALUE) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    generate
        if (N < 2 || N > 32 || D < 1) begin : g_bad_params
            $info("bin2bcd_seq: N=%0d must be 2..32 and D=%0d must be >= 1", N, D);
        end else if (D < bcd_digits_for(N)) begin : g_narrow
            $info("bin2bcd_seq: D=%0d digits cannot hold every %0d-bit value; overflow will be flagged", D, N);
        end
    endgenerate

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [N-1:0]     r_bin, w_bin_nxt;
    logic [4*D-1:0]   r_scr, w_scr_nxt;
    logic             r_ovf_scr, w_ovf_scr_nxt;
    logic [4*D-1:0]   r_bcd, w_bcd_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_done, w_done_nxt;

    logic [4*D-1:0]   w_adj;
    logic [4*D-1:0]   w_shift_scr;
    logic             w_shift_ovf;
    logic             w_last;

    generate
        for (genvar g = 0; g < D; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_scr[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit would start digit D; any such bit means value >= 10^D
    assign w_shift_scr = {w_adj[4*D-2:0], r_bin[N-1]};
    assign w_shift_ovf = r_ovf_scr | w_adj[4*D-1];
    assign w_last      = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_scr     <= '0;
            r_ovf_scr <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bin     <= w_bin_nxt;
            r_scr     <= w_scr_nxt;
            r_ovf_scr <= w_ovf_scr_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bin_nxt     = r_bin;
        w_scr_nxt     = r_scr;
        w_ovf_scr_nxt = r_ovf_scr;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_bin_nxt     = bus.binary_in;
                    w_scr_nxt     = '0;
                    w_ovf_scr_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bin_nxt     = {r_bin[N-2:0], 1'b0};
                w_scr_nxt     = w_shift_scr;
                w_ovf_scr_nxt = w_shift_ovf;
                w_cnt_nxt     = r_cnt + 1'b1;
                if (w_last) begin
                    w_bcd_nxt   = w_shift_scr;
                    w_ovf_nxt   = w_shift_ovf;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (r_state == ST_SHIFT);
    assign bus.done     = r_done;
    assign bus.bcd_out  = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq in three N/D configurations
module tb_bin2bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        int          acc;
        int          val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic        start_v [3];
    logic [31:0] bin_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        ovf_v   [3];
    logic [19:0] bcd_v   [3];
    bit          prev_done [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bin2bcd_seq_if #(.N(8),  .D(3)) if0 ();
    bin2bcd_seq_if #(.N(8),  .D(2)) if1 ();
    bin2bcd_seq_if #(.N(16), .D(5)) if2 ();

    bin2bcd_seq #(.N(8),  .D(3)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    bin2bcd_seq #(.N(8),  .D(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    bin2bcd_seq #(.N(16), .D(5)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.start     = start_v[0];
    assign if1.start     = start_v[1];
    assign if2.start     = start_v[2];
    assign if0.binary_in = bin_v[0][7:0];
    assign if1.binary_in = bin_v[1][7:0];
    assign if2.binary_in = bin_v[2][15:0];

    assign busy_v[0] = if0.busy;
    assign busy_v[1] = if1.busy;
    assign busy_v[2] = if2.busy;
    assign done_v[0] = if0.done;
    assign done_v[1] = if1.done;
    assign done_v[2] = if2.done;
    assign ovf_v[0]  = if0.overflow;
    assign ovf_v[1]  = if1.overflow;
    assign ovf_v[2]  = if2.overflow;
    assign bcd_v[0]  = {8'd0, if0.bcd_out};
    assign bcd_v[1]  = {12'd0, if1.bcd_out};
    assign bcd_v[2]  = if2.bcd_out;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int nd(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic int dd(input int sel);
        return (sel == 0) ? 3 : ((sel == 1) ? 2 : 5);
    endfunction

    // Reference: decimal digits of value mod 10^D, overflow when value needs more than D digits
    function automatic exp_t model(input int sel, input longint v, input int acc);
        exp_t   e;
        longint lim = 1;
        longint r;
        for (int i = 0; i < dd(sel); i++) lim = lim * 10;
        e.ovf = (v >= lim);
        e.bcd = '0;
        e.acc = acc;
        e.val = int'(v);
        r = v % lim;
        for (int i = 0; i < dd(sel); i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return e;
    endfunction

    task automatic check(input string nm, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic qpush(input int sel, input exp_t e);
        case (sel)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int sel);
        case (sel)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic mon(input int sel);
        exp_t e;
        int   sz;
        if (done_v[sel]) begin
            check($sformatf("dut%0d_done_one_cycle", sel), !prev_done[sel], prev_done[sel], 0);
            sz = qsize(sel);
            check($sformatf("dut%0d_done_expected", sel), sz > 0, sz, 1);
            if (sz > 0) begin
                e = qpop(sel);
                check($sformatf("dut%0d_bcd val=%0d", sel, e.val), bcd_v[sel] == e.bcd, bcd_v[sel], e.bcd);
                check($sformatf("dut%0d_ovf val=%0d", sel, e.val), ovf_v[sel] == e.ovf, ovf_v[sel], e.ovf);
                check($sformatf("dut%0d_latency val=%0d", sel, e.val), (cyc - e.acc) == nd(sel), cyc - e.acc, nd(sel));
                check($sformatf("dut%0d_busy_low_at_done", sel), !busy_v[sel], busy_v[sel], 0);
            end
        end
        prev_done[sel] = done_v[sel];
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);
    always @(negedge clk) mon(2);

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic issue(input int sel, input int val, input bit hold, input bit expect_it);
        int g = 0;
        while (busy_v[sel] && g < 100) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("dut%0d_idle_before_start", sel), g < 100, g, 0);
        start_v[sel] = 1'b1;
        bin_v[sel]   = val;
        if (expect_it) qpush(sel, model(sel, longint'(val), cyc + 1));
        @(negedge clk);
        check($sformatf("dut%0d_busy_after_start", sel), busy_v[sel], busy_v[sel], 1);
        if (!hold) start_v[sel] = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int g = 0;
        while (busy_v[sel] && g < 100) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("dut%0d_wait_idle", sel), g < 100, g, 0);
        @(negedge clk);
    endtask

    task automatic sweep(input int sel, input int count);
        bit h;
        for (int i = 0; i < count; i++) begin
            h = 1'($urandom_range(0, 1));
            issue(sel, int'($urandom_range(0, (1 << nd(sel)) - 1)), h, 1'b1);
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        start_v[sel] = 1'b0;
        wait_idle(sel);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation exceeded its cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            bin_v[i]     = '0;
            prev_done[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_reset_busy", i), busy_v[i] == 1'b0, busy_v[i], 0);
            check($sformatf("dut%0d_reset_done", i), done_v[i] == 1'b0, done_v[i], 0);
            check($sformatf("dut%0d_reset_bcd", i), bcd_v[i] == '0, bcd_v[i], 0);
            check($sformatf("dut%0d_reset_ovf", i), ovf_v[i] == 1'b0, ovf_v[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        issue(0, 255, 1'b0, 1'b1);
        wait_idle(0);

        issue(0, 0, 1'b1, 1'b1);
        issue(0, 9, 1'b1, 1'b1);
        issue(0, 10, 1'b1, 1'b1);
        issue(0, 99, 1'b1, 1'b1);
        issue(0, 100, 1'b1, 1'b1);
        start_v[0] = 1'b0;
        wait_idle(0);

        issue(1, 255, 1'b0, 1'b1);
        wait_idle(1);
        issue(1, 99, 1'b0, 1'b1);
        wait_idle(1);

        issue(2, 65535, 1'b0, 1'b1);
        wait_idle(2);

        issue(0, 42, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 17;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        issue(0, 200, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        start_v[0] = 1'b1;
        bin_v[0]   = 7;
        @(negedge clk);
        check("dut0_midreset_busy", busy_v[0] == 1'b0, busy_v[0], 0);
        check("dut0_midreset_done", done_v[0] == 1'b0, done_v[0], 0);
        check("dut0_midreset_bcd", bcd_v[0] == '0, bcd_v[0], 0);
        check("dut0_midreset_ovf", ovf_v[0] == 1'b0, ovf_v[0], 0);
        reset      = 1'b0;
        start_v[0] = 1'b0;
        @(negedge clk);
        check("dut0_start_with_reset_ignored", busy_v[0] == 1'b0, busy_v[0], 0);
        issue(0, 7, 1'b0, 1'b1);
        wait_idle(0);

        fork
            sweep(0, 100);
            sweep(1, 100);
            sweep(2, 1000);
        join

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d_scoreboard_drained", i), qsize(i) == 0, qsize(i), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
